// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding from MEM and WB.
// Feeds the ALU operands, shift amount and opcode, plus store data and writeback control.
module id_ex_stage #(
  parameter int         WIDTH     = 32,
  parameter logic [3:0] NOP_ALUOP = 4'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_alusrc,
  input  logic [4:0]       id_shamt,
  input  logic             id_shamt_src,
  input  logic [3:0]       id_aluop,
  input  logic [4:0]       id_wa,
  input  logic             id_we,
  input  logic [4:0]       mem_wa,
  input  logic [WIDTH-1:0] mem_wd,
  input  logic             mem_we,
  input  logic [4:0]       wb_wa,
  input  logic [WIDTH-1:0] wb_wd,
  input  logic             wb_we,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_op1,
  output logic [WIDTH-1:0] ex_op2,
  output logic [4:0]       ex_shamt,
  output logic [3:0]       ex_aluop,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [4:0]       ex_wa,
  output logic             ex_we
);

  logic             valid_reg;
  logic [WIDTH-1:0] pc_reg;
  logic [4:0]       rs_addr_reg;
  logic [4:0]       rt_addr_reg;
  logic [WIDTH-1:0] rs_val_reg;
  logic [WIDTH-1:0] rt_val_reg;
  logic [WIDTH-1:0] imm_reg;
  logic             alusrc_reg;
  logic [4:0]       shamt_reg;
  logic             shamt_src_reg;
  logic [3:0]       aluop_reg;
  logic [4:0]       wa_reg;
  logic             we_reg;

  // Source operand 0 is rs, operand 1 is rt; both share one forwarding rule.
  logic [1:0][4:0]       src_addr;
  logic [1:0][WIDTH-1:0] src_val;
  logic [1:0][WIDTH-1:0] fwd_val;
  logic [WIDTH-1:0]      fwd_rs;
  logic [WIDTH-1:0]      fwd_rt;

  assign src_addr[0] = rs_addr_reg;
  assign src_addr[1] = rt_addr_reg;
  assign src_val[0]  = rs_val_reg;
  assign src_val[1]  = rt_val_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit;
      logic wb_hit;
      // Register 0 is hard-wired; never let a stage "write" it into EX.
      assign mem_hit = mem_we && (mem_wa != 5'd0) && (mem_wa == src_addr[gi]);
      assign wb_hit  = wb_we  && (wb_wa  != 5'd0) && (wb_wa  == src_addr[gi]);
      assign fwd_val[gi] = mem_hit ? mem_wd :
                           wb_hit  ? wb_wd  : src_val[gi];
    end
  endgenerate

  assign fwd_rs = fwd_val[0];
  assign fwd_rt = fwd_val[1];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_reg     <= 1'b0;
      pc_reg        <= '0;
      rs_addr_reg   <= 5'd0;
      rt_addr_reg   <= 5'd0;
      rs_val_reg    <= '0;
      rt_val_reg    <= '0;
      imm_reg       <= '0;
      alusrc_reg    <= 1'b0;
      shamt_reg     <= 5'd0;
      shamt_src_reg <= 1'b0;
      aluop_reg     <= NOP_ALUOP;
      wa_reg        <= 5'd0;
      we_reg        <= 1'b0;
    end else if (stall) begin
      // Capture forwarded values so they survive the producer leaving WB.
      rs_val_reg <= fwd_rs;
      rt_val_reg <= fwd_rt;
    end else begin
      valid_reg     <= id_valid;
      pc_reg        <= id_pc;
      rs_addr_reg   <= id_rs_addr;
      rt_addr_reg   <= id_rt_addr;
      rs_val_reg    <= id_rs_data;
      rt_val_reg    <= id_rt_data;
      imm_reg       <= id_imm;
      alusrc_reg    <= id_alusrc;
      shamt_reg     <= id_shamt;
      shamt_src_reg <= id_shamt_src;
      aluop_reg     <= id_aluop;
      wa_reg        <= id_wa;
      we_reg        <= id_we & id_valid;
    end
  end

  assign ex_valid      = valid_reg;
  assign ex_pc         = pc_reg;
  assign ex_op1        = fwd_rs;
  assign ex_op2        = alusrc_reg ? imm_reg : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_shamt      = shamt_src_reg ? fwd_rs[4:0] : shamt_reg;
  assign ex_aluop      = aluop_reg;
  assign ex_wa         = wa_reg;
  assign ex_we         = we_reg & valid_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load, forwarding priority, stall capture, flush and reset.
module tb_id_ex_stage;
  localparam int         WIDTH = 32;
  localparam logic [3:0] NOP   = 4'hF;

  logic             clk = 1'b0;
  logic             reset, stall, flush;
  logic             id_valid, id_alusrc, id_shamt_src, id_we;
  logic [WIDTH-1:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]       id_rs_addr, id_rt_addr, id_shamt, id_wa;
  logic [3:0]       id_aluop;
  logic [4:0]       mem_wa, wb_wa;
  logic [WIDTH-1:0] mem_wd, wb_wd;
  logic             mem_we, wb_we;
  logic             ex_valid, ex_we;
  logic [WIDTH-1:0] ex_pc, ex_op1, ex_op2, ex_store_data;
  logic [4:0]       ex_shamt, ex_wa;
  logic [3:0]       ex_aluop;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.WIDTH(WIDTH), .NOP_ALUOP(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alusrc(id_alusrc),
    .id_shamt(id_shamt), .id_shamt_src(id_shamt_src), .id_aluop(id_aluop), .id_wa(id_wa),
    .id_we(id_we), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_we(mem_we),
    .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_we(wb_we),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_shamt(ex_shamt), .ex_aluop(ex_aluop), .ex_store_data(ex_store_data),
    .ex_wa(ex_wa), .ex_we(ex_we)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_fwd;
    mem_we = 0; mem_wa = 0; mem_wd = 0;
    wb_we  = 0; wb_wa  = 0; wb_wd  = 0;
  endtask

  task automatic set_id(input logic v, input logic [WIDTH-1:0] pc,
                        input logic [4:0] rs, input logic [WIDTH-1:0] rsd,
                        input logic [4:0] rt, input logic [WIDTH-1:0] rtd,
                        input logic [4:0] wa, input logic we);
    id_valid = v; id_pc = pc; id_rs_addr = rs; id_rs_data = rsd;
    id_rt_addr = rt; id_rt_data = rtd; id_wa = wa; id_we = we;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    id_imm = 0; id_alusrc = 0; id_shamt = 0; id_shamt_src = 0; id_aluop = 0;
    clear_fwd();
    tick(); tick();
    check("rst_valid", ex_valid, 0);
    check("rst_we", ex_we, 0);
    check("rst_aluop", ex_aluop, NOP);
    check("rst_pc", ex_pc, 0);

    // 1: addu $3,$1,$2
    reset = 0;
    set_id(1, 32'h100, 1, 32'h5, 2, 32'h7, 3, 1);
    id_aluop = 4'd2;
    tick();
    check("t1_op1", ex_op1, 32'h5);
    check("t1_op2", ex_op2, 32'h7);
    check("t1_store", ex_store_data, 32'h7);
    check("t1_wa", ex_wa, 3);
    check("t1_we", ex_we, 1);
    check("t1_valid", ex_valid, 1);
    check("t1_pc", ex_pc, 32'h100);
    check("t1_aluop", ex_aluop, 4'd2);
    reset = 1;
    tick();
    check("t1r_valid", ex_valid, 0);
    check("t1r_we", ex_we, 0);
    check("t1r_op1", ex_op1, 0);
    check("t1r_op2", ex_op2, 0);
    check("t1r_wa", ex_wa, 0);
    check("t1r_aluop", ex_aluop, NOP);
    reset = 0;

    // 2: forwarding priority and register 0
    set_id(1, 32'h104, 1, 32'h99, 0, 0, 3, 1);
    tick();
    mem_we = 1; mem_wa = 1; mem_wd = 32'hAAAA0000;
    wb_we  = 1; wb_wa  = 1; wb_wd  = 32'h11111111;
    #1 check("t2_mem_prio", ex_op1, 32'hAAAA0000);
    mem_we = 0;
    #1 check("t2_wb", ex_op1, 32'h11111111);
    wb_we = 0;
    #1 check("t2_nofwd", ex_op1, 32'h99);
    set_id(1, 32'h108, 0, 0, 0, 0, 3, 1);
    tick();
    mem_we = 1; mem_wa = 0; mem_wd = 32'hAAAA0000;
    wb_we  = 1; wb_wa  = 0; wb_wd  = 32'h11111111;
    #1 check("t2_r0", ex_op1, 0);
    clear_fwd();

    // 3: sw with immediate op2 and forwarded store data
    set_id(1, 32'h10C, 0, 0, 4, 32'h44, 0, 0);
    id_alusrc = 1; id_imm = 32'h10;
    tick();
    mem_we = 1; mem_wa = 4; mem_wd = 32'hDEADBEEF;
    #1 check("t3_op2", ex_op2, 32'h10);
    check("t3_store", ex_store_data, 32'hDEADBEEF);
    check("t3_we", ex_we, 0);
    wb_we = 1; wb_wa = 4; wb_wd = 32'h1;
    #1 check("t3_store_prio", ex_store_data, 32'hDEADBEEF);
    clear_fwd();
    id_alusrc = 0; id_imm = 0;

    // 4: variable vs field shift amount
    set_id(1, 32'h110, 6, 32'h1F, 0, 0, 7, 1);
    id_shamt_src = 1; id_shamt = 5'd7;
    tick();
    wb_we = 1; wb_wa = 6; wb_wd = 32'h23;
    #1 check("t4_shamt_var", ex_shamt, 5'd3);
    check("t4_op1", ex_op1, 32'h23);
    id_shamt_src = 0;
    tick();
    check("t4_shamt_fld", ex_shamt, 5'd7);
    clear_fwd();

    // 5: stall keeps a value forwarded from WB
    set_id(1, 32'h200, 2, 32'h50, 0, 0, 5, 1);
    tick();
    wb_we = 1; wb_wa = 2; wb_wd = 32'h1234;
    stall = 1;
    set_id(1, 32'h300, 7, 32'h77, 0, 0, 8, 1);
    #1 check("t5_op1_c0", ex_op1, 32'h1234);
    tick();
    wb_we = 0;
    #1 check("t5_op1_c1", ex_op1, 32'h1234);
    check("t5_pc_hold", ex_pc, 32'h200);
    check("t5_wa_hold", ex_wa, 5);
    tick();
    check("t5_op1_c2", ex_op1, 32'h1234);
    stall = 0;
    tick();
    check("t5_new_pc", ex_pc, 32'h300);
    check("t5_new_op1", ex_op1, 32'h77);
    check("t5_new_wa", ex_wa, 8);
    clear_fwd();

    // 6: flush beats stall; invalid ID never writes
    stall = 1; flush = 1;
    tick();
    check("t6_valid", ex_valid, 0);
    check("t6_we", ex_we, 0);
    check("t6_aluop", ex_aluop, NOP);
    stall = 0; flush = 0;
    set_id(0, 32'h400, 1, 32'h11, 2, 32'h22, 9, 1);
    tick();
    check("t6_inv_we", ex_we, 0);
    check("t6_inv_valid", ex_valid, 0);
    check("t6_inv_wa", ex_wa, 9);

    // Reset during stall still inserts a bubble
    set_id(1, 32'h500, 1, 32'h11, 2, 32'h22, 10, 1);
    tick();
    check("t7_loaded", ex_we, 1);
    stall = 1; reset = 1;
    tick();
    check("t7_valid", ex_valid, 0);
    check("t7_pc", ex_pc, 0);
    stall = 0; reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
